// File: rtl/board_scanout.sv
// Raster scan-out of the 160x120 one-bit board: reads every cell through the
// registered memory port and emits one VGA plot strobe per pixel.
module board_scanout #(
  parameter int         WIDTH      = 160,
  parameter int         HEIGHT     = 120,
  parameter logic [2:0] ON_COLOUR  = 3'b111,
  parameter logic [2:0] OFF_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       hold,
  output logic       rd_en,
  output logic [7:0] indexX,
  output logic [7:0] indexY,
  input  logic       mem_data,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t     state, state_next;
  logic [7:0] x;
  logic [6:0] y;
  logic       last_cell;
  logic       vld_p1;
  logic [7:0] x_p1;
  logic [6:0] y_p1;

  function automatic logic [2:0] cell_colour(input logic bit_val);
    return bit_val ? ON_COLOUR : OFF_COLOUR;
  endfunction

  assign last_cell = (x == 8'(WIDTH - 1)) && (y == 7'(HEIGHT - 1));
  assign rd_en     = (state == SCAN) && !hold;
  assign indexX    = x;
  assign indexY    = {1'b0, y};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // DRAIN waits until both pipeline stages are empty so frame_done lands
  // exactly one cycle after the final plot.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (enable) state_next = SCAN;
      SCAN:  if (rd_en && last_cell) state_next = DRAIN;
      DRAIN: begin
        if (!vld_p1 && !vga_plot) begin
          frame_done = 1'b1;
          state_next = enable ? SCAN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (state != SCAN) begin
      x <= '0;
      y <= '0;
    end else if (rd_en) begin
      if (x == 8'(WIDTH - 1)) begin
        x <= '0;
        y <= (y == 7'(HEIGHT - 1)) ? 7'd0 : y + 7'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  // Stage 1: address captured alongside the read; mem_data valid this stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
    end else begin
      vld_p1 <= rd_en;
      x_p1   <= x;
      y_p1   <= y;
    end
  end

  // Stage 2: pixel outputs; coordinates and colour hold while no plot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= vld_p1;
      if (vld_p1) begin
        vga_x      <= x_p1;
        vga_y      <= y_p1;
        vga_colour <= cell_colour(mem_data);
      end
    end
  end

endmodule

// File: tb/tb_board_scanout.sv
// Scoreboard bench for board_scanout: expected pixels are queued per frame and
// a negedge monitor pops and compares them on every vga_plot.
module tb_board_scanout;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       hold;
  logic       rd_en;
  logic [7:0] indexX;
  logic [7:0] indexY;
  logic       mem_data = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       frame_done;

  board_scanout dut (
    .clk(clk), .resetn(resetn), .enable(enable), .hold(hold),
    .rd_en(rd_en), .indexX(indexX), .indexY(indexY), .mem_data(mem_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  bit          board [120][160];
  logic [17:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          frames_seen = 0;
  int          plots = 0;
  logic        prev_plot = 1'b0;

  // Board memory with a registered read port.
  always @(posedge clk) if (rd_en) mem_data <= board[indexY][indexX];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd_en"}, rd_en, 0);
    check({name, "_plot"}, vga_plot, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_frame_done"}, frame_done, 0);
    check({name, "_index"}, {indexX, indexY}, 0);
    check({name, "_vga_xy"}, {vga_x, vga_y, vga_colour}, 0);
  endtask

  task automatic push_frame();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        exp_q.push_back({8'(xx), 7'(yy), board[yy][xx] ? 3'b111 : 3'b000});
  endtask

  task automatic wait_addr(input int ax, input int ay);
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (rd_en && indexX == 8'(ax) && indexY == 8'(ay)) return;
    end
    check($sformatf("timeout_addr_%0d_%0d", ax, ay), 0, 1);
  endtask

  task automatic wait_frame_done();
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    check("timeout_frame_done", 0, 1);
  endtask

  // Monitor: pops one expected pixel per plot; frame_done must follow a plot.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!resetn) begin
      plots = 0;
      prev_plot = 1'b0;
    end else begin
      if (vga_plot) begin
        if (exp_q.size() == 0) begin
          check("unexpected_plot", {vga_x, vga_y}, 0);
          if ({vga_x, vga_y} == 15'd0) check("unexpected_plot_at_origin", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {vga_x, vga_y, vga_colour}, e);
        end
        plots++;
      end
      if (frame_done) begin
        check("frame_done_after_plot", prev_plot, 1);
        check("frame_done_with_plot", vga_plot, 0);
        check("plots_per_frame", plots, 19200);
        frames_seen++;
        plots = 0;
      end
      prev_plot = vga_plot;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pv;
    resetn = 1'b0;
    enable = 1'b0;
    hold   = 1'b0;
    board[0][5]   = 1'b1;
    board[0][159] = 1'b1;
    board[1][0]   = 1'b1;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Frame A: start-up latency, hold bubble, enable drop, final hold.
    push_frame();
    enable = 1'b1;
    @(negedge clk); check("idle_rd_en", rd_en, 0);
    @(negedge clk); check("first_rd_en", rd_en, 1);
    check("first_busy", busy, 1);
    check("first_index", {indexX, indexY}, 0);
    @(negedge clk); check("plot_latency_early", vga_plot, 0);
    @(negedge clk); check("first_plot", vga_plot, 1);
    check("first_plot_xyc", {vga_x, vga_y, vga_colour}, 0);

    wait_addr(9, 4);
    @(posedge clk); #1 hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pv[i] = vga_plot;
      if (i < 3) begin
        check("hold_rd_en", rd_en, 0);
        check("hold_index", {indexX, indexY}, {8'd10, 8'd4});
      end
      if (i == 3) begin
        check("hold_release_rd_en", rd_en, 1);
        check("hold_release_index", {indexX, indexY}, {8'd10, 8'd4});
      end
      if (i == 2) begin
        @(posedge clk); #1 hold = 1'b0;
      end
    end
    check("hold_bubble_pattern", pv, 7'b1100011);

    wait_addr(50, 60);
    @(posedge clk); #1 enable = 1'b0;

    wait_addr(158, 119);
    @(posedge clk); #1 hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("final_hold_rd_en", rd_en, 0);
      check("final_hold_busy", busy, 1);
      check("final_hold_index", {indexX, indexY}, {8'd159, 8'd119});
      check("final_hold_done", frame_done, 0);
    end
    @(posedge clk); #1 hold = 1'b0;
    @(negedge clk); check("final_read", rd_en, 1);
    @(negedge clk); check("final_drain_done", frame_done, 0);
    @(negedge clk); check("last_plot", vga_plot, 1);
    check("last_plot_xy", {vga_x, vga_y}, {8'd159, 7'd119});
    check("last_plot_done", frame_done, 0);
    @(negedge clk); check("frame_done_pulse", frame_done, 1);
    @(negedge clk); check("idle_busy", busy, 0);
    check("idle_no_read", rd_en, 0);
    check("idle_done_low", frame_done, 0);
    check("frames_after_a", frames_seen, 1);

    // Frames B and C back to back; reset abandons C.
    push_frame();
    push_frame();
    @(posedge clk); #1 enable = 1'b1;
    wait_frame_done();
    @(negedge clk); check("restart_rd_en", rd_en, 1);
    check("restart_index", {indexX, indexY}, 0);
    check("restart_busy", busy, 1);

    wait_addr(80, 30);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    check("frames_after_reset", frames_seen, 2);

    push_frame();
    #1 resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vga_plot) break;
    end
    check("post_reset_plot", vga_plot, 1);
    check("post_reset_xy", {vga_x, vga_y}, 0);
    repeat (40) @(negedge clk);
    check("post_reset_progress", exp_q.size() < 19200 - 30, 1);
    check("frames_total", frames_seen, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_scanout.md
Name: board_scanout

Overview:
- Reader side of the 160x120 one-bit board memory.
- Sweeps every cell in raster order (x inner, y outer) through the memory's registered read port.
- Converts each bit to a colour and issues one plot strobe per pixel to the VGA adapter's pixel-write interface.
- Yields the shared index bus to the drawing/write path whenever `hold` is asserted, so painting and refresh can share one memory port.

Parameters:
- `WIDTH`, 160, board columns; x range 0..WIDTH-1.
- `HEIGHT`, 120, board rows; y range 0..HEIGHT-1.
- `ON_COLOUR`, 3'b111, colour plotted for a board bit of 1.
- `OFF_COLOUR`, 3'b000, colour plotted for a board bit of 0.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; while high, frames run back to back.
- `hold`  in  1  write path owns the memory port this cycle; no read issued.
- `rd_en`  out  1  read strobe to board memory.
- `indexX`  out  8  read column address.
- `indexY`  out  8  read row address.
- `mem_data`  in  1  board memory registered read data; valid the cycle after `rd_en`.
- `vga_x`  out  8  pixel column.
- `vga_y`  out  7  pixel row.
- `vga_colour`  out  3  pixel colour.
- `vga_plot`  out  1  one-cycle pixel write strobe.
- `busy`  out  1  high in SCAN or DRAIN.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is plotted.

Behaviour:
- Reset (`resetn` low, asynchronous):
  - State goes to IDLE.
  - Scan counters go to 0; pipeline valid bits are cleared.
  - `rd_en`, `vga_plot`, `busy` and `frame_done` are 0.
  - `indexX`, `indexY`, `vga_x`, `vga_y` and `vga_colour` are 0.
  - Reset mid-frame abandons the frame with no `frame_done`. After release, scanning restarts at (0,0) when `enable` is high.
- States:
  - IDLE:
    - `rd_en` = 0.
    - If `enable` = 1, go to SCAN with x = 0, y = 0.
  - SCAN:
    - `rd_en` = !`hold`.
    - `indexX` = x and `indexY` = y, driven combinationally from the counters.
    - When `hold` = 1: counters are frozen and no read is issued.
    - When `hold` = 0: x increments. When x = WIDTH-1, x wraps to 0 and y increments.
    - When a read is issued at (WIDTH-1, HEIGHT-1), go to DRAIN.
  - DRAIN:
    - No reads are issued.
    - Stay until both pipeline valid bits are 0.
    - Then pulse `frame_done` for one cycle and go to SCAN at (0,0) if `enable` = 1, else go to IDLE.
- Pipeline (fixed read-to-plot latency of 2 cycles):
  - Stage 1 registers {valid = `rd_en`, x, y} at the edge ending the read cycle.
  - `mem_data` is valid during stage 1.
  - Stage 2 registers {`vga_plot` = stage1.valid, `vga_x`, `vga_y`, `vga_colour` = `mem_data` ? ON_COLOUR : OFF_COLOUR}.
  - A read issued in cycle N therefore plots in cycle N+2.
  - `hold` never cancels a read already issued; the bubble propagates as `vga_plot` = 0 two cycles later.
  - `vga_x`, `vga_y` and `vga_colour` hold their last values while `vga_plot` = 0.
- `enable` is sampled only in IDLE and at the DRAIN exit. Deasserting it mid-frame lets the frame finish.
- `busy` = 1 in SCAN and in DRAIN.
- `frame_done` is asserted in the cycle after the last `vga_plot`, and never at the same time as `vga_plot`.
- With no `hold`, one frame takes WIDTH*HEIGHT read cycles plus DRAIN, i.e. 19200 `vga_plot` pulses per frame.
- Counter widths: x uses 8 bits and y uses 7 bits; `indexY` is the zero-extended y. Coordinates are never out of range.

Test Plan:
- Reset then `enable` = 1, `hold` = 0, board all zeros:
  - `rd_en` rises 1 cycle after the IDLE->SCAN transition.
  - First `vga_plot` occurs 2 cycles after the first `rd_en`, at (0,0) with colour 3'b000.
  - Exactly 19200 plots occur, then a single `frame_done`.
- Board cells (5,0), (159,0) and (0,1) set to 1:
  - Those plots carry 3'b111; all others carry 3'b000.
  - The plot after (159,0) is (0,1), confirming x wrap and y increment.
- `hold` pulsed high for 3 cycles while the read address is (10,4):
  - `rd_en` = 0 for those 3 cycles and the address stays frozen.
  - `vga_plot` drops for exactly 3 cycles.
  - No pixel is skipped or duplicated, and (10,4) is plotted once.
- `hold` held high across the final read at (159,119):
  - The last pixel is read only after `hold` falls.
  - `frame_done` follows the last plot by 1 cycle.
- `enable` dropped at pixel (50,60):
  - The frame still completes with 19200 plots, then `frame_done`, then IDLE with `busy` = 0.
  - With `enable` held high instead, the next frame starts at (0,0) directly after `frame_done`.
- `resetn` asserted at pixel (80,30):
  - All outputs go to 0 immediately, asynchronously.
  - No `frame_done` is produced.
  - After release with `enable` = 1, the first plot is (0,0).
